bus_arbiter: RTL and testbench

Two-master arbiter sharing the single memory bus of the simple CPU. Master 0 is the CPU control unit's bus port; master 1 is a secondary requester such as a program loader or debug port. The block serialises transactions with round-robin priority and issues exactly one start pulse per transaction to the bus slave. It routes the completion pulse back to the owning master only.

---
 rtl/bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory bus: one s_start per
// transaction, completion routed to the owner. Optional WAIT timeout via BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_mode,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_mode,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic              m0_err,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic              m1_err,
    output logic [DATA_W-1:0] m_rdata,
    output logic              s_start,
    output logic              s_mode,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_rdata_valid,
    input  logic              s_write_done,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q, last_d;

    logic              own_mode;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              own_phase;
    logic              cmpl;
    logic              to_hit;
    logic              fin;

    assign own_mode  = owner_q ? m1_mode  : m0_mode;
    assign own_addr  = owner_q ? m1_addr  : m0_addr;
    assign own_wdata = owner_q ? m1_wdata : m0_wdata;
    assign own_phase = (state_q == ISSUE) || (state_q == WAIT);

    // Only the completion type matching the owner's mode counts; the other is ignored.
    assign cmpl = (state_q == WAIT) && (own_mode ? s_write_done : s_rdata_valid);
    assign fin  = cmpl || to_hit;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ISSUE)     cnt_d = '0;
        else if (state_q == WAIT) cnt_d = cnt_q + 16'd1;
    end

    // Fires in the TIMEOUT-th WAIT cycle; a completion in that same cycle wins.
    assign to_hit = (state_q == WAIT) && !cmpl && (cnt_q == 16'(TIMEOUT - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = ISSUE;
                    owner_d = (m0_req && m1_req) ? ~last_q : m1_req;
                end
            end
            ISSUE: begin
                last_d  = owner_q;
                state_d = WAIT;
            end
            WAIT: begin
                if (fin) state_d = RELEASE;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        m0_done = 1'b0;
        m1_done = 1'b0;
        m0_err  = 1'b0;
        m1_err  = 1'b0;
        s_start = 1'b0;
        s_mode  = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        busy    = (state_q != IDLE);
        m_rdata = s_rdata;
        if (own_phase) begin
            m0_gnt  = ~owner_q;
            m1_gnt  = owner_q;
            s_mode  = own_mode;
            s_addr  = own_addr;
            s_wdata = own_wdata;
        end
        s_start = (state_q == ISSUE);
        if (fin) begin
            m0_done = ~owner_q;
            m1_done = owner_q;
            m0_err  = to_hit & ~owner_q;
            m1_err  = to_hit & owner_q;
        end
    end

`ifndef SYNTHESIS
    a_gnt_excl  : assert property (@(posedge clk) disable iff (rst) !(m0_gnt && m1_gnt));
    a_done_excl : assert property (@(posedge clk) disable iff (rst) !(m0_done && m1_done));
    a_start_1c  : assert property (@(posedge clk) disable iff (rst) s_start |=> !s_start);
    a_err0_done : assert property (@(posedge clk) disable iff (rst) m0_err |-> m0_done);
    a_err1_done : assert property (@(posedge clk) disable iff (rst) m1_err |-> m1_done);
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized traffic, all checked each
// cycle against a transaction-level model (owner, age in transaction, cool-down flag).
module tb_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req_a [2];
    logic mode_a[2];
    logic [AW-1:0] addr_a[2];
    logic [DW-1:0] wd_a[2];
    logic m0_req, m0_mode, m1_req, m1_mode;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [DW-1:0] m_rdata, s_wdata;
    logic [DW-1:0] s_rdata = '0;
    logic [AW-1:0] s_addr;
    logic s_start, s_mode, busy;
    logic s_rdata_valid = 1'b0, s_write_done = 1'b0;

    assign m0_req = req_a[0];  assign m0_mode = mode_a[0];
    assign m0_addr = addr_a[0]; assign m0_wdata = wd_a[0];
    assign m1_req = req_a[1];  assign m1_mode = mode_a[1];
    assign m1_addr = addr_a[1]; assign m1_wdata = wd_a[1];

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_mode(m0_mode), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_mode(m1_mode), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err),
        .m_rdata(m_rdata), .s_start(s_start), .s_mode(s_mode), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_rdata_valid(s_rdata_valid),
        .s_write_done(s_write_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_act, m_own, m_lst, m_cool;
    int m_age;   // 0 = start cycle, k>0 = k-th cycle waiting for the slave

    task automatic model_reset();
        m_act = 0; m_own = 0; m_lst = 1; m_cool = 0; m_age = 0;
    endtask

    function automatic bit m_owner_mode();
        return m_own ? mode_a[1] : mode_a[0];
    endfunction

    function automatic bit m_cmpl();
        return m_act && (m_age > 0) && (m_owner_mode() ? s_write_done : s_rdata_valid);
    endfunction

    function automatic bit m_to();
`ifdef BUS_ARB_TIMEOUT_EN
        return m_act && (m_age == TO) && !m_cmpl();
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (m_cool) begin
            m_cool = 0;
        end else if (!m_act) begin
            if (req_a[0] || req_a[1]) begin
                m_own = (req_a[0] && req_a[1]) ? !m_lst : req_a[1];
                m_act = 1; m_age = 0;
            end
        end else if (m_age == 0) begin
            m_lst = m_own; m_age = 1;
        end else if (m_cmpl() || m_to()) begin
            m_act = 0; m_cool = 1;
        end else begin
            m_age++;
        end
    endtask

    task automatic check_outputs();
        bit ph, cm, to, o;
        ph = m_act; o = m_own; cm = m_cmpl(); to = m_to();
        chk("gnt0", m0_gnt, ph && !o);
        chk("gnt1", m1_gnt, ph && o);
        chk("start", s_start, m_act && m_age == 0);
        chk("s_mode", s_mode, ph ? m_owner_mode() : 1'b0);
        chk("s_addr", s_addr, ph ? addr_a[o] : '0);
        chk("s_wdata", s_wdata, ph ? wd_a[o] : '0);
        chk("done0", m0_done, (cm || to) && !o);
        chk("done1", m1_done, (cm || to) && o);
        chk("err0", m0_err, to && !o);
        chk("err1", m1_err, to && o);
        chk("busy", busy, m_act || m_cool);
        chk("m_rdata", m_rdata, s_rdata);
    endtask

    // ---------------- stimulus state ----------------
    int  policy = 2;     // 0 random slave, 1 reply after D, 2 silent, 3 typing, 4 one stray rv
    int  D = 1;
    logic [DW-1:0] rd_val = '0;
    bit  hold[2], autor[2], drop_next[2], pend[2];
    bit  pmode[2];
    logic [AW-1:0] paddr[2];
    logic [DW-1:0] pwd[2];
    int  rst_cycles = 0;
    bit  in_flight = 0, st_mode = 0;
    int  st_cnt = 0, cyc = 0, raise_cyc = 0;
    int  done_cnt[2], err_cnt[2], start_cnt;
    int  start_log[$], start_cyc[$], done_cyc[$];
    logic [DW-1:0] rd_at_done;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_wdata;

    task automatic raise(input int x, input bit md, input logic [AW-1:0] a, input logic [DW-1:0] w);
        pend[x] = 1; pmode[x] = md; paddr[x] = a; pwd[x] = w;
    endtask

    task automatic clear_stats();
        done_cnt = '{0, 0}; err_cnt = '{0, 0}; start_cnt = 0;
        start_log.delete(); start_cyc.delete(); done_cyc.delete();
        rd_at_done = '0; st_addr = '0; st_wdata = '0;
    endtask

    task automatic drive();
        if (rst_cycles > 0) begin
            rst = 1; rst_cycles--;
            model_reset();
            for (int x = 0; x < 2; x++) begin req_a[x] = 0; drop_next[x] = 0; end
            in_flight = 0;
        end else begin
            rst = 0;
        end
        for (int x = 0; x < 2; x++) begin
            if (pend[x] && !rst) begin
                pend[x] = 0; req_a[x] = 1; mode_a[x] = pmode[x];
                addr_a[x] = paddr[x]; wd_a[x] = pwd[x]; raise_cyc = cyc;
            end else if (drop_next[x]) begin
                drop_next[x] = 0;
                if (!hold[x] && (policy != 0 || $urandom_range(0, 9) < 7)) req_a[x] = 0;
            end else if (!req_a[x] && autor[x] && !rst && $urandom_range(0, 9) < 4) begin
                req_a[x] = 1; mode_a[x] = $urandom_range(0, 1);
                addr_a[x] = $urandom; wd_a[x] = $urandom;
            end
        end
        s_rdata_valid = 0; s_write_done = 0;
        if (in_flight) st_cnt++;
        case (policy)
            0: begin
                s_rdata = $urandom;
                s_rdata_valid = ($urandom_range(0, 4) == 0);
                s_write_done  = ($urandom_range(0, 4) == 0);
            end
            1: begin
                s_rdata = rd_val;
                if (in_flight && st_cnt == D) begin
                    if (st_mode) s_write_done = 1; else s_rdata_valid = 1;
                end
            end
            3: begin
                if (in_flight && st_cnt == 1) s_rdata_valid = 1;
                if (in_flight && st_cnt == 3) s_write_done = 1;
            end
            4: begin s_rdata_valid = 1; policy = 2; end
            default: ;
        endcase
    endtask

    task automatic observe();
        if (m0_done || m1_done) begin
            in_flight = 0; rd_at_done = m_rdata; done_cyc.push_back(cyc);
        end
        if (m0_done) begin done_cnt[0]++; drop_next[0] = 1; end
        if (m1_done) begin done_cnt[1]++; drop_next[1] = 1; end
        if (m0_err) err_cnt[0]++;
        if (m1_err) err_cnt[1]++;
        if (s_start) begin
            start_cnt++; start_log.push_back(int'(m1_gnt)); start_cyc.push_back(cyc);
            in_flight = 1; st_cnt = 0; st_mode = s_mode; st_addr = s_addr; st_wdata = s_wdata;
        end
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cyc++;
            drive();
            #4;
            check_outputs();
            observe();
            model_step();
        end
    endtask

    task automatic fresh(input int pol);
        rst_cycles = 1; policy = 2;
        hold = '{0, 0}; autor = '{0, 0};
        cycle(2);
        policy = pol;
        clear_stats();
    endtask

    initial begin
        for (int x = 0; x < 2; x++) begin
            req_a[x] = 0; mode_a[x] = 0; addr_a[x] = '0; wd_a[x] = '0;
            pend[x] = 0; drop_next[x] = 0;
        end
        model_reset();
        rst_cycles = 2;
        cycle(4);

        // single read from m0
        fresh(1); D = 3; rd_val = 32'hDEADBEEF;
        raise(0, 0, 32'h10, 32'h0);
        cycle(12);
        chk("rd_starts", start_cnt, 1);
        chk("rd_addr", st_addr, 32'h10);
        chk("rd_done0", done_cnt[0], 1);
        chk("rd_done1", done_cnt[1], 0);
        chk("rd_data", rd_at_done, 32'hDEADBEEF);
        chk("rd_lat", (done_cyc.size() > 0 && start_cyc.size() > 0) ? done_cyc[0] - start_cyc[0] : -1, 3);

        // tie after reset, both held continuously
        fresh(1); D = 2; hold = '{1, 1};
        raise(0, 0, 32'hA0, 32'h0);
        raise(1, 0, 32'hB0, 32'h0);
        cycle(30);
        chk("tie_nstarts", start_log.size() >= 4, 1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("tie_order%0d", i), (i < start_log.size()) ? start_log[i] : 9, i % 2);

        // write completion typing on m1
        fresh(3);
        raise(1, 1, 32'h20, 32'h55);
        cycle(10);
        chk("wr_done1", done_cnt[1], 1);
        chk("wr_done0", done_cnt[0], 0);
        chk("wr_wdata", st_wdata, 32'h55);
        chk("wr_lat", (done_cyc.size() > 0 && start_cyc.size() > 0) ? done_cyc[0] - start_cyc[0] : -1, 3);

        // reset while waiting, then a stray completion
        fresh(2);
        raise(0, 0, 32'h30, 32'h0);
        cycle(4);
        chk("rmw_inwait", busy, 1);
        rst_cycles = 1;
        cycle(1);
        policy = 4;
        cycle(4);
        chk("rmw_done", done_cnt[0] + done_cnt[1], 0);
        chk("rmw_busy", busy, 0);
        chk("rmw_gnt", {m0_gnt, m1_gnt, s_start}, 3'b000);

        // slave never answers
        fresh(2);
        raise(0, 0, 32'h40, 32'h0);
        cycle(14);
`ifdef BUS_ARB_TIMEOUT_EN
        chk("to_err0", err_cnt[0], 1);
        chk("to_done0", done_cnt[0], 1);
        chk("to_lat", (done_cyc.size() > 0 && start_cyc.size() > 0) ? done_cyc[0] - start_cyc[0] : -1, TO);
`else
        chk("nto_busy", busy, 1);
        chk("nto_done", done_cnt[0], 0);
`endif

        // minimum latency, m0 re-requesting
        fresh(1); D = 1; hold = '{1, 0};
        raise(0, 0, 32'h50, 32'h0);
        cycle(12);
        chk("min_req_done", (done_cyc.size() > 0) ? done_cyc[0] - raise_cyc : -1, 2);
        chk("min_done_start", (done_cyc.size() > 0 && start_cyc.size() > 1) ? start_cyc[1] - done_cyc[0] : -1, 3);

        // randomized traffic with occasional resets
        fresh(0); autor = '{1, 1};
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) rst_cycles = $urandom_range(1, 2);
            cycle(1);
        end
        chk("rnd_progress", start_cnt > 50, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
